// File: rtl/cipher_msg_framer.sv
// cipher_msg_framer: store-and-forward framer that buffers one message, then replays it
// to the keystream cipher as a new_message pulse followed by a gap-free byte burst.
`default_nettype none

module cipher_msg_framer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       new_message,
  output logic [7:0] key,
  output logic [7:0] data_in,
  output logic       valid_in,
  output logic       trunc,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DROP   = 3'd2,
    S_START  = 3'd3,
    S_STREAM = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_ADDR0 = '0;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_rd;
  logic [7:0]        r_key;
  logic [7:0]        r_data;
  logic              r_in_ready;
  logic              r_new_message;
  logic              r_valid_in;
  logic              r_trunc;

  logic              w_hs;
  logic              w_wr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_fill_end;
  logic              w_rd_done;

  assign w_hs       = in_valid & r_in_ready;
  assign w_wr       = w_hs & ((r_state == S_IDLE) | (r_state == S_LOAD));
  assign w_wr_addr  = (r_state == S_IDLE) ? c_ADDR0 : r_count[ADDR_W-1:0];
  assign w_fill_end = ((r_count + 1'b1) == c_DEPTH);
  // r_rd counts bytes already presented; reaching r_count ends the burst
  assign w_rd_done  = (r_rd == r_count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next = in_last ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          if (in_last) begin
            w_next = S_START;
          end else if (w_fill_end) begin
            w_next = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (w_hs && in_last) begin
          w_next = S_START;
        end
      end
      S_START: begin
        w_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_rd_done) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_key   <= 8'h00;
      r_trunc <= 1'b0;
    end else begin
      if (w_hs && (r_state == S_IDLE)) begin
        r_count <= {{ADDR_W{1'b0}}, 1'b1};
        r_key   <= in_key;
      end else if (w_hs && (r_state == S_LOAD)) begin
        r_count <= r_count + 1'b1;
      end
      r_trunc <= w_hs && (r_state == S_LOAD) && !in_last && w_fill_end;
    end
  end

  // Cipher-side outputs are registered from the next state so they carry no input path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready    <= 1'b0;
      r_new_message <= 1'b0;
      r_rd          <= '0;
      r_data        <= 8'h00;
      r_valid_in    <= 1'b0;
    end else begin
      r_in_ready    <= (w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_DROP);
      r_new_message <= (w_next == S_START);
      if (r_state == S_START) begin
        r_rd       <= {{ADDR_W{1'b0}}, 1'b1};
        r_data     <= r_mem[c_ADDR0];
        r_valid_in <= 1'b1;
      end else if ((r_state == S_STREAM) && !w_rd_done) begin
        r_rd       <= r_rd + 1'b1;
        r_data     <= r_mem[r_rd[ADDR_W-1:0]];
        r_valid_in <= 1'b1;
      end else begin
        if (r_state == S_STREAM) begin
          r_rd <= '0;
        end
        r_data     <= 8'h00;
        r_valid_in <= 1'b0;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign new_message = r_new_message;
  assign key         = r_key;
  assign data_in     = r_data;
  assign valid_in    = r_valid_in;
  assign trunc       = r_trunc;
  assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cipher_msg_framer.sv
// tb_cipher_msg_framer: drives framed messages with random gaps/keys and checks the
// cipher-side replay against a per-message expectation built from the sent bytes.
`default_nettype none

module tb_cipher_msg_framer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic [7:0] in_key = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       new_message;
  logic [7:0] key;
  logic [7:0] data_in;
  logic       valid_in;
  logic       trunc;
  logic       busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         trunc_cyc[$];
  logic [7:0] tb_msg [16];

  cipher_msg_framer #(.DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_key      (in_key),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .new_message (new_message),
    .key         (key),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .trunc       (trunc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trunc === 1'b1) trunc_cyc.push_back(cyc);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, 32'(in_ready), 0);
    check_val({tag, "_newmsg"}, 32'(new_message), 0);
    check_val({tag, "_key"}, 32'(key), 0);
    check_val({tag, "_data"}, 32'(data_in), 0);
    check_val({tag, "_valid"}, 32'(valid_in), 0);
    check_val({tag, "_trunc"}, 32'(trunc), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Called at a negedge while the framer is idle. Sends tb_msg[0..n-1] with key k.
  // gap<0 picks random idle gaps between bytes; hold keeps in_valid high while streaming;
  // rst_at>=0 asserts reset during that stream byte and abandons the message.
  task automatic send_msg(input int n, input logic [7:0] k, input int gap,
                          input bit hold, input int rst_at);
    int L;
    int exp_trunc_cyc;
    L = (n < DEPTH) ? n : DEPTH;
    exp_trunc_cyc = -1;
    trunc_cyc.delete();
    for (int i = 0; i < n; i++) begin
      int g;
      g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
      repeat (g) begin
        in_valid = 1'b0;
        check_val("ready_gap", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = tb_msg[i];
      in_last  = (i == n - 1);
      in_key   = (i == 0) ? k : 8'($urandom);
      check_val("ready_load", 32'(in_ready), 1);
      if (i == DEPTH - 1 && n > DEPTH) exp_trunc_cyc = cyc + 1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = hold;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    in_key   = 8'h5A;
    check_val("newmsg_pulse", 32'(new_message), 1);
    check_val("key_latched", 32'(key), 32'(k));
    check_val("start_valid", 32'(valid_in), 0);
    check_val("start_data", 32'(data_in), 0);
    check_val("start_ready", 32'(in_ready), 0);
    check_val("start_busy", 32'(busy), 1);
    for (int j = 0; j < L; j++) begin
      @(negedge clk);
      if (j == rst_at) begin
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_ready", 32'(in_ready), 1);
        check_val("rst_busy", 32'(busy), 0);
        return;
      end
      check_val("stream_valid", 32'(valid_in), 1);
      check_val("stream_data", 32'(data_in), 32'(tb_msg[j]));
      check_val("stream_newmsg", 32'(new_message), 0);
      check_val("stream_ready", 32'(in_ready), 0);
      check_val("stream_key", 32'(key), 32'(k));
    end
    @(negedge clk);
    check_val("end_ready", 32'(in_ready), 1);
    check_val("end_valid", 32'(valid_in), 0);
    check_val("end_data", 32'(data_in), 0);
    check_val("end_busy", 32'(busy), 0);
    check_val("trunc_count", 32'(trunc_cyc.size()), (n > DEPTH) ? 1 : 0);
    if (exp_trunc_cyc >= 0)
      check_val("trunc_cycle", (trunc_cyc.size() > 0) ? 32'(trunc_cyc[0]) : 32'hFFFF_FFFF,
                32'(exp_trunc_cyc));
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_val("post_reset_ready", 32'(in_ready), 1);
    check_val("post_reset_busy", 32'(busy), 0);

    tb_msg[0] = 8'hAA;
    send_msg(1, 8'h00, 0, 1'b0, -1);

    tb_msg[0] = 8'h11; tb_msg[1] = 8'h22; tb_msg[2] = 8'h33; tb_msg[3] = 8'h44;
    send_msg(4, 8'h3C, 2, 1'b0, -1);

    for (int m = 0; m < 4; m++) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) tb_msg[i] = 8'($urandom);
      send_msg(n, 8'($urandom), 0, 1'b1, -1);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 10; i++) tb_msg[i] = 8'(i + 1);
    send_msg(10, 8'h77, 0, 1'b0, -1);

    for (int i = 0; i < DEPTH; i++) tb_msg[i] = 8'($urandom);
    send_msg(DEPTH, 8'hC3, -1, 1'b0, -1);

    for (int i = 0; i < 4; i++) tb_msg[i] = 8'(8'hA0 + i);
    send_msg(4, 8'h99, 0, 1'b0, 1);
    tb_msg[0] = 8'h5D;
    send_msg(1, 8'h42, 0, 1'b0, -1);

    for (int m = 0; m < 20; m++) begin
      int n;
      n = int'($urandom_range(1, DEPTH + 4));
      for (int i = 0; i < n; i++) tb_msg[i] = 8'($urandom);
      send_msg(n, 8'($urandom), -1, 1'($urandom_range(0, 1)), -1);
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
